// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner
//
// Scans a ROWS x COLS switch matrix by driving one column at a time. It
// debounces both press and release, and hands each key to the consumer as a
// binary code over a Valid/Ready handshake. The default parameters give the
// classic 16-key hex keypad, with codes 0x0-0xF.
//
// Optional feature: define KEYPAD_SYNC_EN to add an internal two-flop
// synchroniser on Row. This delays s_row by 2 cycles, so SCAN_DWELL must be
// >= 3. When the macro is undefined, Row is used directly. In that case the
// caller must synchronise Row externally and fold that latency into
// SCAN_DWELL.
//
// Ports:
//   clock  in   1       single clock for all state
//   reset  in   1       synchronous, active-high reset
//   Row    in   ROWS    row sense lines, active-high
//   Col    out  COLS    column drive, active-high (all ones while idle)
//   Code   out  CODE_W  key code = row_index*COLS + col_index
//   Valid  out  1       Code holds a debounced key that is not yet accepted
//   Ready  in   1       consumer accepts Code when Valid && Ready
//   Held   out  1       accepted key is still down (waiting for release)

module keypad_matrix_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CODE_W          = $clog2(ROWS*COLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ROWS-1:0]   Row,
  output logic [COLS-1:0]   Col,
  output logic [CODE_W-1:0] Code,
  output logic              Valid,
  input  logic              Ready,
  output logic              Held
);

  localparam int CNT_MAX = (SCAN_DWELL > DEBOUNCE_CYCLES) ? SCAN_DWELL : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int CIW     = $clog2(COLS);
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0]  DWELL_LAST = CW'(SCAN_DWELL - 1);
  localparam logic [CW-1:0]  DB_DONE    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CIW-1:0] COL_LAST   = CIW'(COLS - 1);

  typedef enum logic [2:0] {IDLE, SCAN, DEBOUNCE, REPORT, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [CIW-1:0]    col_idx_reg, col_idx_next;
  logic [RW-1:0]     row_idx_reg, row_idx_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [COLS-1:0]   col_reg, col_next;
  logic [CODE_W-1:0] code_reg, code_next;
  logic              valid_reg, valid_next;
  logic              held_reg, held_next;

  logic [ROWS-1:0]   s_row;
  logic [RW-1:0]     low_row;
  logic              key_bit;

`ifdef KEYPAD_SYNC_EN
  logic [ROWS-1:0] sync1_reg, sync2_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= Row;
      sync2_reg <= sync1_reg;
    end
  end

  assign s_row = sync2_reg;
`else
  assign s_row = Row;
`endif

  // Lowest set row wins when several keys share the hitting column.
  always_comb begin
    low_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (s_row[r]) low_row = RW'(r);
    end
  end

  // The latched key's row line; the column stays driven from DEBOUNCE onwards.
  assign key_bit = s_row[row_idx_reg];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      col_idx_reg <= '0;
      row_idx_reg <= '0;
      cnt_reg     <= '0;
      col_reg     <= '1;
      code_reg    <= '0;
      valid_reg   <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      col_idx_reg <= col_idx_next;
      row_idx_reg <= row_idx_next;
      cnt_reg     <= cnt_next;
      col_reg     <= col_next;
      code_reg    <= code_next;
      valid_reg   <= valid_next;
      held_reg    <= held_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    col_idx_next = col_idx_reg;
    row_idx_next = row_idx_reg;
    cnt_next     = cnt_reg;
    code_next    = code_reg;
    valid_next   = valid_reg;
    held_next    = held_reg;

    case (state_reg)
      IDLE: begin
        if (|s_row) begin
          state_next   = SCAN;
          col_idx_next = '0;
          cnt_next     = '0;
        end
      end

      SCAN: begin
        if (cnt_reg == DWELL_LAST) begin
          cnt_next = '0;
          if (|s_row) begin
            row_idx_next = low_row;
            state_next   = DEBOUNCE;
          end else if (col_idx_reg == COL_LAST) begin
            state_next = IDLE;
          end else begin
            col_idx_next = col_idx_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // The count completes on one edge, and REPORT (with Valid) follows on
      // the next edge. This adds one cycle to the press latency.
      DEBOUNCE: begin
        if (cnt_reg == DB_DONE) begin
          state_next = REPORT;
          valid_next = 1'b1;
          code_next  = CODE_W'(32'(row_idx_reg) * COLS + 32'(col_idx_reg));
          cnt_next   = '0;
        end else if (key_bit) begin
          cnt_next = cnt_reg + 1'b1;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end

      // Release while waiting does not withdraw the key; only Ready moves on.
      REPORT: begin
        if (Ready) begin
          state_next = HOLD;
          valid_next = 1'b0;
          held_next  = 1'b1;
          cnt_next   = '0;
        end
      end

      HOLD: begin
        if (cnt_reg == DB_DONE) begin
          state_next = IDLE;
          held_next  = 1'b0;
          cnt_next   = '0;
        end else if (key_bit) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Col is registered from the next state so the pins never glitch.
    if (state_next == IDLE) col_next = '1;
    else                    col_next = COLS'(1) << col_idx_next;
  end

  assign Col   = col_reg;
  assign Code  = code_reg;
  assign Valid = valid_reg;
  assign Held  = held_reg;

endmodule
